// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared constants and types for the SPI 12864 (ST7565-class) LCD
// initialisation stage.
//   INIT_CMD_NUM / INIT_CMD : fixed power-up command table, element 0 first
//   LCD_PAGES / LCD_COLS    : display RAM geometry used by the clear phase
//   A0_BIT                  : position of the A0 (command/data) flag in the
//                             9-bit SPI word
//   init_state_t            : sequencer states
// Optional build macro: LCD_INIT_CLEAR_EN adds the CLR_SEND/CLR_GAP states.
// ---------------------------------------------------------------------------
package lcd_pkg;

    localparam int INIT_CMD_NUM = 11;

    // Packed so element 0 (E2, software reset) sits in the low byte.
    localparam logic [INIT_CMD_NUM-1:0][7:0] INIT_CMD = {
        8'hAF, 8'hA6, 8'h40, 8'h24, 8'h81, 8'h24,
        8'h2F, 8'hC8, 8'hA0, 8'hA2, 8'hE2
    };

    localparam int LCD_PAGES = 8;
    localparam int LCD_COLS  = 128;

    // A0 = 0 selects the command register, A0 = 1 selects display RAM.
    localparam int A0_BIT = 8;

    typedef enum logic [3:0] {
        IDLE,
        RST_LOW,
        RST_WAIT,
        CMD_SEND,
        CMD_GAP,
`ifdef LCD_INIT_CLEAR_EN
        CLR_SEND,
        CLR_GAP,
`endif
        DONE,
        RELEASE
    } init_state_t;

endpackage

// File: rtl/lcd_init_seq_delay_cnt.sv
// ---------------------------------------------------------------------------
// lcd_delay_cnt
// Load/expire down-counter shared by every timed state of the sequencer.
// Loading N-1 on state entry makes the state last exactly N cycles, because
// the state is left on the cycle the count reads zero.
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : value to load
//   expired  : count is zero
// ---------------------------------------------------------------------------
module lcd_delay_cnt #(
    parameter int CNT_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    // Counts down to zero and parks there; it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/lcd_init_seq.sv
// ---------------------------------------------------------------------------
// lcd_init_seq
// Initialisation stage for an SPI 12864 (ST7565-class) LCD. On a request it
// pulses the panel hardware reset, waits for power-up, then writes the fixed
// command table through the SPI byte-writer handshake and pulses done.
//   CLK            : system clock
//   RST            : asynchronous active-high reset
//   Init_Start_Sig : level request from the controller
//   Init_Done_Sig  : one-cycle completion pulse
//   SPI_Start_Sig  : level request to the SPI byte writer
//   SPI_Data       : {A0, byte}; A0 = 0 command, 1 display data
//   SPI_Done_Sig   : one-cycle pulse when the byte has shifted out
//   LCD_RSTn       : panel hardware reset, active low
// Optional build macro: LCD_INIT_CLEAR_EN clears all of display RAM
// (8 pages x 128 columns) after the command table and before done.
// ---------------------------------------------------------------------------
module lcd_init_seq
    import lcd_pkg::*;
#(
    parameter int RST_LOW_CYC  = 50000,
    parameter int RST_WAIT_CYC = 250000,
    parameter int CMD_GAP_CYC  = 50,
    parameter int CNT_W        = 18
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Init_Start_Sig,
    output logic       Init_Done_Sig,
    output logic       SPI_Start_Sig,
    output logic [8:0] SPI_Data,
    input  logic       SPI_Done_Sig,
    output logic       LCD_RSTn
);

    localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(RST_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RST_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(CMD_GAP_CYC - 1);

    init_state_t      state;
    init_state_t      next_state;
    logic [3:0]       cmd_idx;
    logic             last_cmd;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_expired;

    assign last_cmd = (cmd_idx == 4'(INIT_CMD_NUM - 1));

`ifdef LCD_INIT_CLEAR_EN
    // clr_step 0..2 are the page/column address commands, 3..130 the data bytes.
    logic [2:0] clr_page;
    logic [7:0] clr_step;
    logic       clr_last_step;
    logic       clr_last_page;
    logic [8:0] clr_word;

    assign clr_last_step = (clr_step == 8'(LCD_COLS + 2));
    assign clr_last_page = (clr_page == 3'(LCD_PAGES - 1));
`endif

    lcd_delay_cnt #(
        .CNT_W (CNT_W)
    ) u_delay (
        .clk      (CLK),
        .rst      (RST),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .expired  (cnt_expired)
    );

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Any state change reloads the delay counter, so every
    // state starts with a fresh count (zero for states that are not timed).
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:     if (Init_Start_Sig) next_state = RST_LOW;
            RST_LOW:  if (cnt_expired)    next_state = RST_WAIT;
            RST_WAIT: if (cnt_expired)    next_state = CMD_SEND;
            CMD_SEND: begin
                if (SPI_Done_Sig) begin
                    if (last_cmd) begin
`ifdef LCD_INIT_CLEAR_EN
                        next_state = CLR_GAP;
`else
                        next_state = DONE;
`endif
                    end else begin
                        next_state = CMD_GAP;
                    end
                end
            end
            CMD_GAP:  if (cnt_expired)    next_state = CMD_SEND;
`ifdef LCD_INIT_CLEAR_EN
            CLR_SEND: begin
                if (SPI_Done_Sig) begin
                    next_state = (clr_last_step && clr_last_page) ? DONE : CLR_GAP;
                end
            end
            CLR_GAP:  if (cnt_expired)    next_state = CLR_SEND;
`endif
            DONE:     next_state = RELEASE;
            // Hold here until the controller drops its request so a level
            // still high from this run cannot start another one.
            RELEASE:  if (!Init_Start_Sig) next_state = IDLE;
            default:  next_state = IDLE;
        endcase

        cnt_load     = (next_state != state);
        cnt_load_val = '0;
        unique case (next_state)
            RST_LOW:  cnt_load_val = LOW_LOAD;
            RST_WAIT: cnt_load_val = WAIT_LOAD;
            CMD_GAP:  cnt_load_val = GAP_LOAD;
`ifdef LCD_INIT_CLEAR_EN
            CLR_GAP:  cnt_load_val = GAP_LOAD;
`endif
            default:  cnt_load_val = '0;
        endcase
    end

    // Command table index: cleared while idle, advanced on each acknowledged
    // command except the last, so it still points at AF when the table ends.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cmd_idx <= '0;
        end else if (state == IDLE) begin
            cmd_idx <= '0;
        end else if (state == CMD_SEND && SPI_Done_Sig && !last_cmd) begin
            cmd_idx <= cmd_idx + 1'b1;
        end
    end

`ifdef LCD_INIT_CLEAR_EN
    // Clear-phase position: step walks the 3 address commands plus 128 data
    // bytes of one page, then wraps to 0 and the page advances.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            clr_page <= '0;
            clr_step <= '0;
        end else if (state == IDLE) begin
            clr_page <= '0;
            clr_step <= '0;
        end else if (state == CLR_SEND && SPI_Done_Sig) begin
            if (clr_last_step) begin
                clr_step <= '0;
                clr_page <= clr_page + 1'b1;
            end else begin
                clr_step <= clr_step + 1'b1;
            end
        end
    end

    // Word for the current clear step: set page, column high nibble 0,
    // column low nibble 0, then zero data bytes.
    always_comb begin
        clr_word = '0;
        unique case (clr_step)
            8'd0:    clr_word[7:0] = 8'hB0 | {5'b0, clr_page};
            8'd1:    clr_word[7:0] = 8'h10;
            8'd2:    clr_word[7:0] = 8'h00;
            default: clr_word[A0_BIT] = 1'b1;
        endcase
    end
`endif

    // Outputs are decoded from the registered state and indices only.
    always_comb begin
        Init_Done_Sig = (state == DONE);
        LCD_RSTn      = (state != RST_LOW);
        SPI_Start_Sig = 1'b0;
        SPI_Data      = '0;
        if (state == CMD_SEND) begin
            SPI_Start_Sig  = 1'b1;
            SPI_Data[7:0]  = INIT_CMD[cmd_idx];
        end
`ifdef LCD_INIT_CLEAR_EN
        if (state == CLR_SEND) begin
            SPI_Start_Sig = 1'b1;
            SPI_Data      = clr_word;
        end
`endif
    end

endmodule
